// File: rtl/top.sv
// ============================================================================
// top -- self-contained 5-bit ALU demo system
//
// An internal controller (instance controller1) walks a hardwired
// 5-instruction program.  Every instruction takes three clocks after the
// first one: FETCH loads A/B/OP from the ROM, EXEC registers the ALU result,
// and WRITE copies that result to the output with a signed "greater than
// zero" flag.  After the last WRITE the controller parks in DONE with done
// high until reset.
//
// Ports (top):
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high; clears all state
//   result        out  5  registered ALU result of the last completed instr
//   flag_gt_zero  out  1  result read as 5-bit two's complement is > 0
//   done          out  1  whole program executed; held until reset
// ============================================================================

module controller (
    input  logic       clk,
    input  logic       reset,
    output logic [4:0] result,
    output logic       flag_gt_zero,
    output logic       done
);

    localparam int WIDTH     = 5;
    localparam int NUM_INSTR = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        FETCH = 3'b001,
        EXEC  = 3'b010,
        WRITE = 3'b011,
        DONE  = 3'b100
    } state_t;

    // Externally probed registers keep their plain names.
    state_t             pstate;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         OP;

    state_t             pstate_d;
    logic [WIDTH-1:0]   A_d;
    logic [WIDTH-1:0]   B_d;
    logic [2:0]         OP_d;
    logic [2:0]         pc_q,     pc_d;
    logic [WIDTH-1:0]   alu_q,    alu_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               flag_q,   flag_d;
    logic               done_q,   done_d;

    // Program ROM: returns {A, B, OP}.  Out-of-range addresses yield zeros.
    function automatic logic [12:0] rom_f(input logic [2:0] addr);
        logic [12:0] word;
        case (addr)
            3'd0:    word = {5'b00111, 5'b00011, 3'b000};
            3'd1:    word = {5'b00111, 5'b00011, 3'b001};
            3'd2:    word = {5'b00011, 5'b00111, 3'b001};
            3'd3:    word = {5'b10101, 5'b01010, 3'b010};
            3'd4:    word = {5'b00101, 5'b01000, 3'b011};
            default: word = 13'd0;
        endcase
        return word;
    endfunction

    // 5-bit ALU; all results wrap modulo 32, no carry out.
    function automatic logic [4:0] alu_f(input logic [4:0] a,
                                         input logic [4:0] b,
                                         input logic [2:0] op);
        logic [4:0] y;
        case (op)
            3'b000:  y = a + b;
            3'b001:  y = a - b;
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b100:  y = a ^ b;
            3'b101:  y = ~a;
            3'b110:  y = {a[3:0], 1'b0};
            3'b111:  y = {1'b0, a[4:1]};
            default: y = 5'd0;
        endcase
        return y;
    endfunction

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pstate   <= IDLE;
            A        <= 5'd0;
            B        <= 5'd0;
            OP       <= 3'd0;
            pc_q     <= 3'd0;
            alu_q    <= 5'd0;
            result_q <= 5'd0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pstate   <= pstate_d;
            A        <= A_d;
            B        <= B_d;
            OP       <= OP_d;
            pc_q     <= pc_d;
            alu_q    <= alu_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update; everything holds unless its state acts.
    always_comb begin
        pstate_d = pstate;
        A_d      = A;
        B_d      = B;
        OP_d     = OP;
        pc_d     = pc_q;
        alu_d    = alu_q;
        result_d = result_q;
        flag_d   = flag_q;
        done_d   = done_q;
        case (pstate)
            IDLE: begin
                pstate_d = FETCH;
            end
            FETCH: begin
                {A_d, B_d, OP_d} = rom_f(pc_q);
                pstate_d         = EXEC;
            end
            EXEC: begin
                alu_d    = alu_f(A, B, OP);
                pstate_d = WRITE;
            end
            WRITE: begin
                result_d = alu_q;
                // Positive in two's complement: sign bit clear and non-zero.
                flag_d   = ~alu_q[4] & (|alu_q);
                if (pc_q == 3'(NUM_INSTR - 1)) begin
                    pstate_d = DONE;
                    done_d   = 1'b1;
                end else begin
                    pc_d     = pc_q + 3'd1;
                    pstate_d = FETCH;
                end
            end
            DONE: begin
                pstate_d = DONE;
                done_d   = 1'b1;
            end
            default: begin
                pstate_d = IDLE;
            end
        endcase
    end

    assign result       = result_q;
    assign flag_gt_zero = flag_q;
    assign done         = done_q;

endmodule

module top (
    input  logic       clk,
    input  logic       reset,
    output logic [4:0] result,
    output logic       flag_gt_zero,
    output logic       done
);

    controller controller1 (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .flag_gt_zero (flag_gt_zero),
        .done         (done)
    );

endmodule

// File: tb/tb_top.sv
// ============================================================================
// tb_top -- directed bench for the 5-bit ALU demo system (top)
// ============================================================================
`timescale 1ns/1ps

module tb_top;

    logic       clk;
    logic       reset;
    logic [4:0] result;
    logic       flag_gt_zero;
    logic       done;

    int checks;
    int failures;

    top dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .flag_gt_zero (flag_gt_zero),
        .done         (done)
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after each edge 1..16 following reset release.
    logic [4:0] exp_res  [1:16];
    logic       exp_flag [1:16];
    logic [2:0] exp_st   [1:16];

    task automatic build_tables();
        for (int e = 1; e <= 16; e++) begin
            if      (e < 4)  begin exp_res[e] = 5'd0;  exp_flag[e] = 1'b0; end
            else if (e < 7)  begin exp_res[e] = 5'd10; exp_flag[e] = 1'b1; end
            else if (e < 10) begin exp_res[e] = 5'd4;  exp_flag[e] = 1'b1; end
            else if (e < 13) begin exp_res[e] = 5'd28; exp_flag[e] = 1'b0; end
            else if (e < 16) begin exp_res[e] = 5'd0;  exp_flag[e] = 1'b0; end
            else             begin exp_res[e] = 5'd13; exp_flag[e] = 1'b1; end
            // Edge 1 enters FETCH, then FETCH/EXEC/WRITE repeat every 3 edges.
            case (e % 3)
                1:       exp_st[e] = 3'b001;
                2:       exp_st[e] = 3'b010;
                default: exp_st[e] = 3'b011;
            endcase
        end
        exp_st[16] = 3'b100;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #10;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (result !== 5'd0 || flag_gt_zero !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%0d flag=%0b done=%0b, want 0/0/0",
                     result, flag_gt_zero, done);
        end
        checks++;
        if (dut.controller1.pstate !== 3'b000 || dut.controller1.A !== 5'd0 ||
            dut.controller1.B !== 5'd0 || dut.controller1.OP !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got st=%b A=%b B=%b OP=%b, want all zero",
                     dut.controller1.pstate, dut.controller1.A,
                     dut.controller1.B, dut.controller1.OP);
        end
        #7;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full program run with per-edge checks, probes in pc=2 and done timing.
    task automatic test_run();
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (result !== exp_res[e] || flag_gt_zero !== exp_flag[e]) begin
                failures++;
                $display("FAIL run_result edge %0d: got res=%0d flag=%0b, want res=%0d flag=%0b",
                         e, result, flag_gt_zero, exp_res[e], exp_flag[e]);
            end
            checks++;
            if (done !== (e == 16)) begin
                failures++;
                $display("FAIL run_done edge %0d: got %0b, want %0b", e, done, (e == 16));
            end
            checks++;
            if (dut.controller1.pstate !== exp_st[e]) begin
                failures++;
                $display("FAIL run_state edge %0d: got %b, want %b",
                         e, dut.controller1.pstate, exp_st[e]);
            end
            // Edge 8 is the FETCH edge of pc=2.
            if (e == 8) begin
                checks++;
                if (dut.controller1.A !== 5'b00011 || dut.controller1.B !== 5'b00111 ||
                    dut.controller1.OP !== 3'b001) begin
                    failures++;
                    $display("FAIL fetch_pc2: got A=%b B=%b OP=%b, want 00011 00111 001",
                             dut.controller1.A, dut.controller1.B, dut.controller1.OP);
                end
            end
        end
        checks++;
        if ($time >= 200) begin
            failures++;
            $display("FAIL run_time: done at %0t ns, want < 200 ns", $time);
        end
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || result !== 5'd13 || flag_gt_zero !== 1'b1 ||
                dut.controller1.pstate !== 3'b100) begin
                failures++;
                $display("FAIL done_hold: got done=%0b res=%0d flag=%0b st=%b, want 1 13 1 100",
                         done, result, flag_gt_zero, dut.controller1.pstate);
            end
        end
    endtask

    task automatic test_reset_in_done();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 5'd0 || dut.controller1.pstate !== 3'b000) begin
            failures++;
            $display("FAIL reset_in_done: got done=%0b res=%0d st=%b, want 0 0 000",
                     done, result, dut.controller1.pstate);
        end
        #10;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset mid-EXEC of pc=1, then confirm a clean restart.
    task automatic test_mid_reset();
        for (int e = 1; e <= 5; e++) @(posedge clk);
        #2;
        checks++;
        if (dut.controller1.pstate !== 3'b010 || result !== 5'd10) begin
            failures++;
            $display("FAIL mid_pre: got st=%b res=%0d, want 010 10",
                     dut.controller1.pstate, result);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (result !== 5'd0 || flag_gt_zero !== 1'b0 || done !== 1'b0 ||
            dut.controller1.pstate !== 3'b000 || dut.controller1.A !== 5'd0) begin
            failures++;
            $display("FAIL mid_async_clear: got res=%0d flag=%0b done=%0b st=%b A=%b, want zeros",
                     result, flag_gt_zero, done, dut.controller1.pstate, dut.controller1.A);
        end
        #10;
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (result !== exp_res[e] || flag_gt_zero !== exp_flag[e]) begin
                failures++;
                $display("FAIL restart edge %0d: got res=%0d flag=%0b, want res=%0d flag=%0b",
                         e, result, flag_gt_zero, exp_res[e], exp_flag[e]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        build_tables();
        test_reset();
        test_run();
        test_done_hold();
        test_reset_in_done();
        test_mid_reset();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish by 20000 ns");
        $fatal(1, "timeout");
    end

endmodule
